// File: rtl/counter_updown_param_pkg.sv
// counter_pkg: shared constants and helpers for counter_updown_param.
//   DIR_UP / DIR_DOWN   : encodings of the dir input
//   MODE_WRAP / MODE_SAT: encodings of the sat input
//   clog2()             : prescaler counter width, never less than 1 bit
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // ceil(log2(v)), clamped to 1 so a divide-by-1 prescaler still has a
  // legal (constant-zero) register.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/counter_updown_param_if.sv
// counter_updown_param_if: control/status bundle of the up/down counter.
//   en, dir, load, load_val, sat, clr_ovf : controls (master -> slave)
//   count, tc, ovf, at_max, at_min        : status   (slave -> master)
interface counter_updown_param_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             sat;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             at_max;
  logic             at_min;

  modport master (
    output en, dir, load, load_val, sat, clr_ovf,
    input  count, tc, ovf, at_max, at_min
  );

  modport slave (
    input  en, dir, load, load_val, sat, clr_ovf,
    output count, tc, ovf, at_max, at_min
  );
endinterface

// File: rtl/counter_updown_param_step_prescaler.sv
// step_prescaler: divides en-high cycles by PRESCALE into single-cycle steps.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   en    : advance enable; low freezes the count
//   clr   : synchronous restart of the interval (wins over en)
//   step  : high on the edge that completes an interval
module step_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int unsigned    PW   = clog2(PRESCALE);
  localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc_q;

  // clr masks the step so a load always takes priority over counting.
  assign step = en && !clr && (psc_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       psc_q <= '0;
    else if (clr)     psc_q <= '0;
    else if (en)      psc_q <= (psc_q == LAST) ? '0 : psc_q + PW'(1);
  end

endmodule

// File: rtl/counter_updown_param.sv
// counter_updown_param: parametrised up/down event/timebase counter.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of counter_updown_param_if
//     en/dir/sat      count enable, direction, saturate-vs-wrap
//     load/load_val   synchronous parallel load (clamped to MAX)
//     clr_ovf         synchronous clear of the sticky ovf flag
//     count/tc/ovf    registered count, terminal-count pulse, sticky flag
//     at_max/at_min   combinational bound decodes of count
module counter_updown_param
  import counter_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter longint unsigned MAX       = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     PRESCALE  = 1,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  counter_updown_param_if.slave  bus
);

  // Elaboration-time range checks.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter_updown_param: WIDTH must be 2..32");
  end
  if (MAX > ((64'd1 << WIDTH) - 64'd1) || MAX == 0) begin : g_bad_max
    $error("counter_updown_param: MAX must be 1..2**WIDTH-1");
  end
  if (RESET_VAL > MAX) begin : g_bad_rst
    $error("counter_updown_param: RESET_VAL must not exceed MAX");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_psc
    $error("counter_updown_param: PRESCALE must be 1..65535");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, ovf_q;
  logic             step, bnd;

  step_prescaler #(.PRESCALE(PRESCALE)) u_psc (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clr   (bus.load),
    .step  (step)
  );

  // Next-count mux: load > step > hold. bnd flags a step taken at a bound,
  // in either wrap or saturate mode.
  always_comb begin
    cnt_d = cnt_q;
    bnd   = 1'b0;
    if (bus.load) begin
      cnt_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
    end else if (step) begin
      if (bus.dir == DIR_UP) begin
        if (cnt_q == MAX_V) begin
          bnd   = 1'b1;
          cnt_d = (bus.sat == MODE_SAT) ? MAX_V : '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          bnd   = 1'b1;
          cnt_d = (bus.sat == MODE_SAT) ? '0 : MAX_V;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= RST_V;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= bnd;
      // A boundary event on the same edge as clr_ovf keeps the flag set.
      if (bnd)              ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign bus.count  = cnt_q;
  assign bus.tc     = tc_q;
  assign bus.ovf    = ovf_q;
  assign bus.at_max = (cnt_q == MAX_V);
  assign bus.at_min = (cnt_q == '0);

endmodule
